fault_campaign_ctrl: RTL
========================

Name: fault_campaign_ctrl

Overview:
Sequencer that runs a fault-injection campaign on the single-cycle core pair (golden and faulty instance). For each fault site it resets both cores, enables the selected fault, and runs a fixed cycle budget while comparing PC and writeback result. It emits one result record per fault over a valid/ready handshake. It sits above both core tops, drives their shared core reset and the fault-select bus, and is the only block that controls campaign timing.

Parameters:
NUM_FAULTS, 64, number of fault sites; fault ids run 0..NUM_FAULTS-1.
FID_W, $clog2(NUM_FAULTS), fault id width.
RUN_CYCLES, 256, core cycles executed per fault.
CYC_W, $clog2(RUN_CYCLES), cycle counter width.
RST_CYCLES, 2, cycles core reset is held low before each run (minimum 1).
EARLY_STOP, 1, 1 = end the run on first mismatch; 0 = always run the full budget.

Ports:
clk  in  1  campaign clock, same clock as both cores.
rst  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; starts a campaign when IDLE, ignored otherwise.
abort  in  1  level; forces return to IDLE.
golden_pc  in  32  PC_Top_Out of golden core.
golden_result  in  32  Result_Out of golden core.
faulty_pc  in  32  PC_Top_Out of faulty core.
faulty_result  in  32  Result_Out of faulty core.
core_rst  out  1  active-low reset to both cores.
fault_en  out  1  enables the fault at fault_id in the faulty core.
fault_id  out  FID_W  currently selected fault site.
busy  out  1  high from accepted start until return to IDLE.
done  out  1  one-cycle pulse when the last record is accepted.
rec_valid  out  1  result record valid.
rec_ready  in  1  consumer accepts the record.
rec_fault_id  out  FID_W  fault id of the record.
rec_detected  out  1  a mismatch was seen during the run.
rec_cycle  out  CYC_W  run cycle of the first mismatch; 0 if not detected.
det_count  out  FID_W+1  detected faults in the current campaign.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, core_rst=0, fault_en=0, fault_id=0, busy=0, done=0, rec_valid=0, rec_detected=0, rec_cycle=0, rec_fault_id=0, det_count=0.
- IDLE: core_rst=0, fault_en=0. On start: fault_id=0, det_count=0, busy=1, go to CRST.
- CRST: core_rst=0, fault_en=1. Hold for RST_CYCLES cycles, then go to RUN. fault_id is stable throughout CRST and RUN.
- RUN: core_rst=1, run_cnt starts at 0 on the first RUN cycle.
  - Each RUN cycle, mismatch = (golden_pc != faulty_pc) || (golden_result != faulty_result).
  - On the first mismatch, latch detected=1 and cycle=run_cnt.
  - Later mismatches do not update the latched values.
  - Leave RUN when run_cnt==RUN_CYCLES-1, or on the mismatch cycle itself if EARLY_STOP=1. Go to REPORT.
  - A mismatch on cycle RUN_CYCLES-1 counts as detected.
- REPORT: core_rst=0, fault_en=0. rec_* are registered and stable with rec_valid=1 until rec_valid&&rec_ready.
  - det_count increments by rec_detected in the accept cycle.
  - On accept: if fault_id==NUM_FAULTS-1, pulse done, clear busy, go to IDLE. Otherwise fault_id+1, clear the latches, go to CRST.
  - rec_ready while rec_valid=0 has no effect.
- Handshake: rec_valid never drops without an accept, except on abort or rst.
- abort: takes effect next edge from any state except IDLE. Go to IDLE with core_rst=0, fault_en=0, rec_valid=0, busy=0. No done pulse. det_count is held.
- start during a campaign is ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- Mismatch registered in the same cycle a RUN terminates by budget: reported as detected at cycle RUN_CYCLES-1.
- rst mid-run: immediate return to the reset state; the partial record is lost.
- No output depends combinationally on golden/faulty inputs; all outputs are registered.

Decomposition:
- fault_campaign_pkg holds the state enum (IDLE, CRST, RUN, REPORT) and a packed record struct {fault_id, detected, cycle}, parameterised by localparams mirroring the defaults.
- One sub-module, fault_cmp: combinational 2×32-bit compare producing mismatch, instantiated once.
- FSM, counters and record register stay in fault_campaign_ctrl.

Test Plan:
- NUM_FAULTS=4, faulty core equals golden (no faults active), rec_ready=1 -> 4 records, ids 0..3, detected=0, cycle=0. Each run is RST_CYCLES+256 cycles plus the REPORT cycle. done pulses once, det_count=0.
- Force faulty_result to differ at run cycle 17 for fault 2, EARLY_STOP=1 -> record id 2, detected=1, cycle=17. RUN exits at cycle 17; det_count=1 at done.
- Same stimulus with EARLY_STOP=0 plus a second mismatch at cycle 40 -> cycle=17 and RUN lasts 256 cycles.
- Mismatch only at run cycle 255 -> detected=1, cycle=255.
- rec_ready low for 10 cycles in REPORT -> rec_valid and all rec_* fields held constant; core_rst stays 0; fault_id does not advance.
- abort asserted during RUN of fault 1 -> next cycle IDLE, busy=0, rec_valid=0, no done. A subsequent start restarts from fault_id=0 with det_count cleared.

Source files
------------

// File: rtl/fault_campaign_pkg.sv
// Shared types for the fault-injection campaign sequencer.
// No logic; holds the FSM state encoding, default sizing and the record layout.
// Backpressure: n/a (type definitions only).
package fault_campaign_pkg;

    localparam int DATA_W          = 32;
    localparam int NUM_FAULTS_DEF  = 64;
    localparam int FID_W_DEF       = $clog2(NUM_FAULTS_DEF);
    localparam int RUN_CYCLES_DEF  = 256;
    localparam int CYC_W_DEF       = $clog2(RUN_CYCLES_DEF);
    localparam int RST_CYCLES_DEF  = 2;
    localparam int EARLY_STOP_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CRST   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Record layout at the default campaign size, for consumers that pack the
    // rec_* outputs into a single word (e.g. a result FIFO or log buffer).
    typedef struct packed {
        logic [FID_W_DEF-1:0] fault_id;
        logic                 detected;
        logic [CYC_W_DEF-1:0] cycle;
    } fault_rec_t;

endpackage

// File: rtl/fault_cmp.sv
// Golden/faulty core output comparator: PC and writeback result.
// Latency 0 (purely combinational); the caller registers the result.
// Backpressure: none.
//   golden_pc/golden_result : golden core observation
//   faulty_pc/faulty_result : faulty core observation
//   mismatch                : any bit differs in either field
module fault_cmp
    import fault_campaign_pkg::*;
(
    input  logic [DATA_W-1:0] golden_pc,
    input  logic [DATA_W-1:0] golden_result,
    input  logic [DATA_W-1:0] faulty_pc,
    input  logic [DATA_W-1:0] faulty_result,
    output logic              mismatch
);

    assign mismatch = (golden_pc != faulty_pc) || (golden_result != faulty_result);

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: per fault, reset cores, run, compare, report.
// Per fault: RST_CYCLES reset + up to RUN_CYCLES run + >=1 report cycle; all outputs registered.
// Backpressure: record held stable in REPORT until rec_ready; campaign stalls meanwhile.
//   clk, rst           : campaign clock, async active-low reset
//   start, abort       : campaign control (abort has priority)
//   golden_*, faulty_* : core observations compared every RUN cycle
//   core_rst, fault_en, fault_id : core control
//   busy, done, det_count        : campaign status
//   rec_valid/rec_ready, rec_fault_id, rec_detected, rec_cycle : per-fault result record
module fault_campaign_ctrl
    import fault_campaign_pkg::*;
#(
    parameter int NUM_FAULTS = NUM_FAULTS_DEF,
    parameter int FID_W      = $clog2(NUM_FAULTS),
    parameter int RUN_CYCLES = RUN_CYCLES_DEF,
    parameter int CYC_W      = $clog2(RUN_CYCLES),
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int EARLY_STOP = EARLY_STOP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] golden_pc,
    input  logic [DATA_W-1:0] golden_result,
    input  logic [DATA_W-1:0] faulty_pc,
    input  logic [DATA_W-1:0] faulty_result,
    output logic              core_rst,
    output logic              fault_en,
    output logic [FID_W-1:0]  fault_id,
    output logic              busy,
    output logic              done,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [FID_W-1:0]  rec_fault_id,
    output logic              rec_detected,
    output logic [CYC_W-1:0]  rec_cycle,
    output logic [FID_W:0]    det_count
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FID_W-1:0] LAST_FID = FID_W'(NUM_FAULTS - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(RUN_CYCLES - 1);
    localparam logic [RCW-1:0]   LAST_RST = RCW'(RST_CYCLES - 1);

    state_t             state_q, state_d;
    logic [FID_W-1:0]   fault_id_d;
    logic [FID_W:0]     det_count_d;
    logic [CYC_W-1:0]   run_cnt_q, run_cnt_d;
    logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
    logic               det_d;
    logic [CYC_W-1:0]   cyc_d;
    logic               busy_d;
    logic               done_d;
    logic               mismatch;
    logic               accept;

    fault_cmp u_cmp (
        .golden_pc     (golden_pc),
        .golden_result (golden_result),
        .faulty_pc     (faulty_pc),
        .faulty_result (faulty_result),
        .mismatch      (mismatch)
    );

    // The record fault id is the live fault id register; it only moves on accept.
    assign rec_fault_id = fault_id;
    assign accept       = rec_valid && rec_ready;

    always_comb begin
        state_d     = state_q;
        fault_id_d  = fault_id;
        det_count_d = det_count;
        run_cnt_d   = run_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        det_d       = rec_detected;
        cyc_d       = rec_cycle;
        busy_d      = busy;
        done_d      = 1'b0;

        if (abort && (state_q != IDLE)) begin
            // det_count and fault_id are left as they were for post-mortem.
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d     = CRST;
                        fault_id_d  = '0;
                        det_count_d = '0;
                        rst_cnt_d   = '0;
                        det_d       = 1'b0;
                        cyc_d       = '0;
                        busy_d      = 1'b1;
                    end
                end
                CRST: begin
                    if (rst_cnt_q == LAST_RST) begin
                        state_d   = RUN;
                        run_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RCW'(1);
                    end
                end
                RUN: begin
                    // Only the first mismatch of a run is recorded.
                    if (mismatch && !rec_detected) begin
                        det_d = 1'b1;
                        cyc_d = run_cnt_q;
                    end
                    if ((run_cnt_q == LAST_CYC) || ((EARLY_STOP != 0) && mismatch)) begin
                        state_d = REPORT;
                    end else begin
                        run_cnt_d = run_cnt_q + CYC_W'(1);
                    end
                end
                REPORT: begin
                    if (accept) begin
                        det_count_d = det_count + (FID_W+1)'(rec_detected);
                        if (fault_id == LAST_FID) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d    = CRST;
                            fault_id_d = fault_id + FID_W'(1);
                            rst_cnt_d  = '0;
                            det_d      = 1'b0;
                            cyc_d      = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Core-facing and handshake outputs are registered from the next state so
    // they line up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fault_id     <= '0;
            det_count    <= '0;
            run_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            rec_detected <= 1'b0;
            rec_cycle    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            core_rst     <= 1'b0;
            fault_en     <= 1'b0;
            rec_valid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_id     <= fault_id_d;
            det_count    <= det_count_d;
            run_cnt_q    <= run_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            rec_detected <= det_d;
            rec_cycle    <= cyc_d;
            busy         <= busy_d;
            done         <= done_d;
            core_rst     <= (state_d == RUN);
            fault_en     <= (state_d == CRST) || (state_d == RUN);
            rec_valid    <= (state_d == REPORT);
        end
    end

endmodule
